// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundles the requester-side and transmitter-side signals of uart_tx_arbiter.
//   slave  : the arbiter's view (requests and tx_ready in; acks, grant,
//            tx_start, tx_data, busy out).
//   master : the view of whoever drives the requesters and models uart_tx.
//
// Signals
//   req_valid[NREQ]   requester i has a byte pending
//   req_data[8*NREQ]  byte of requester i at [8i+7:8i]
//   req_lock[NREQ]    requester i wants to keep the grant after this byte
//   req_ack[NREQ]     one-cycle pulse, byte of requester i accepted
//   grant[NREQ]       one-hot current owner of the transmitter, 0 if none
//   tx_start          one-cycle start pulse to uart_tx
//   tx_data[8]        byte presented to uart_tx
//   tx_ready          uart_tx idle flag
//   busy              arbiter is not idle
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_lock;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   grant;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              busy;

    modport slave (
        input  req_valid, req_data, req_lock, tx_ready,
        output req_ack, grant, tx_start, tx_data, busy
    );

    modport master (
        output req_valid, req_data, req_lock, tx_ready,
        input  req_ack, grant, tx_start, tx_data, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx transmitter between NREQ byte sources. Bytes are
// arbitrated round robin, one byte per grant, and the arbiter sequences the
// uart_tx start/ready handshake on behalf of the winner.
//
// Ports
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : uart_tx_arbiter_if.slave (requests, acks, grant, uart_tx handshake)
//
// Parameter
//   NREQ : number of requesters, 2..8
//
// Build option
//   UART_TX_ARB_LOCK_EN : when defined, a grant holder that keeps req_lock
//   high on return to IDLE stays the only eligible requester, so multi-byte
//   replies are not interleaved. When undefined, req_lock is ignored.
//
// All outputs come straight from flops (busy is a decode of the state flop).
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   req_ack_q, req_ack_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic [NREQ-1:0]   eligible;
    logic              locked;
    logic              found;
    logic [IDXW-1:0]   win;
    logic [IDXW-1:0]   cand;

    // Eligible set for the IDLE decision. Under lock the current holder
    // (always the last winner while grant is non-zero) is the only candidate,
    // and its lock keeps the grant even if it has nothing to send right now.
`ifdef UART_TX_ARB_LOCK_EN
    always_comb begin
        locked   = 1'b0;
        eligible = bus.req_valid;
        if ((grant_q != '0) && bus.req_lock[last_q]) begin
            locked   = 1'b1;
            eligible = bus.req_valid & grant_q;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;

    always_comb begin
        locked   = 1'b0;
        eligible = bus.req_valid;
    end
`endif

    // Round-robin search starting after last_q. Scanning from the farthest
    // candidate down to the nearest lets the nearest eligible one win.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDXW'((int'(last_q) + k) % NREQ);
            if (eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        req_ack_d  = '0;

        case (state_q)
            S_IDLE: begin
                // Request changes while uart_tx is still busy are not looked at.
                if (bus.tx_ready) begin
                    if (found) begin
                        state_d    = S_START;
                        last_d     = win;
                        grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << win;
                        req_ack_d  = {{(NREQ-1){1'b0}}, 1'b1} << win;
                        tx_data_d  = bus.req_data[8*int'(win) +: 8];
                        tx_start_d = 1'b1;
                    end else if (!locked) begin
                        grant_d = '0;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!bus.tx_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= IDXW'(NREQ - 1);
            grant_q    <= '0;
            req_ack_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            req_ack_q  <= req_ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.req_ack  = req_ack_q;
    assign bus.grant    = grant_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Drives NREQ byte sources and a behavioural uart_tx, and predicts every
// output of the arbiter each cycle from a transaction-level model: the
// arbiter may accept when uart_tx is ready and at least one cycle has passed
// since the previous byte completed; the winner is the eligible requester
// nearest after the previous winner.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester and uart_tx stimulus state
    logic [7:0]      srcq [NREQ][$];
    logic [7:0]      dat  [NREQ];
    bit              hold [NREQ];
    bit              pend [NREQ];
    int              cool [NREQ];
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] lk;
    int              stall_left;
    bit              u_act;
    int              u_delay;
    int              u_low;
    bit              force_long;

    // Reference model state
    int              m_last;
    int              m_holder;
    bit              m_inflight;
    int              free_edge;
    int              edge_n;
    bit              exp_start;
    int              exp_w;
    logic [NREQ-1:0] exp_ack;
    logic [NREQ-1:0] exp_grant;
    logic [7:0]      exp_data;
    bit              exp_busy;

    logic [7:0]      obs_q [$];

    // Eligible requester with the smallest forward distance from the last winner.
    function automatic int pick(input logic [NREQ-1:0] elig, input int last);
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (elig[i]) begin
                int dd = (i - last - 1 + 2 * NREQ) % NREQ;
                if (dd < bestd) begin
                    bestd = dd;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_last     = NREQ - 1;
        m_holder   = -1;
        m_inflight = 1'b0;
        free_edge  = 0;
        exp_start  = 1'b0;
        exp_w      = 0;
        exp_ack    = '0;
        exp_grant  = '0;
        exp_data   = 8'h00;
        exp_busy   = 1'b0;
    endtask

    // One clock: check what the previous edge produced, react, drive the
    // inputs for the next edge and predict its outcome.
    task automatic step(input bit rst_next);
        logic [NREQ-1:0] elig;
        bit              rdy;
        bit              raise;
        bit              locked;
        int              w;

        @(negedge clk);
        check_val("tx_start", 32'(bus.tx_start), 32'(exp_start));
        check_val("req_ack",  32'(bus.req_ack),  32'(exp_ack));
        check_val("grant",    32'(bus.grant),    32'(exp_grant));
        check_val("tx_data",  32'(bus.tx_data),  32'(exp_data));
        check_val("busy",     32'(bus.busy),     32'(exp_busy));
        if (bus.tx_start === 1'b1) obs_q.push_back(bus.tx_data);

        if (exp_start) begin
            void'(srcq[exp_w].pop_front());
            pend[exp_w] = 1'b0;
            cool[exp_w] = 1;
            u_act       = 1'b1;
            if (force_long) begin
                u_delay    = 0;
                u_low      = 8;
                force_long = 1'b0;
            end else begin
                u_delay = $urandom_range(0, 3);
                u_low   = $urandom_range(2, 5);
            end
        end

        // uart_tx: optionally stays ready a few cycles, then busy, then ready.
        rdy   = 1'b1;
        raise = 1'b0;
        if (u_act) begin
            if (u_delay > 0) begin
                u_delay--;
            end else if (u_low > 0) begin
                u_low--;
                rdy = 1'b0;
            end else begin
                u_act = 1'b0;
                raise = 1'b1;
            end
        end else if (stall_left > 0) begin
            stall_left--;
            rdy = 1'b0;
        end

        // Requesters hold valid and data until their byte is accepted.
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
                v[i] = 1'b1;
            end else if (cool[i] > 0) begin
                cool[i]--;
                v[i] = 1'b0;
            end else begin
                v[i] = (srcq[i].size() > 0) && !hold[i];
            end
            pend[i] = v[i];
            dat[i]  = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
            bus.req_data[8*i +: 8] = dat[i];
        end
        bus.req_valid = v;
        bus.req_lock  = lk;
        bus.tx_ready  = rdy;
        rst           = rst_next;

        exp_start = 1'b0;
        exp_ack   = '0;
        if (rst_next) begin
            model_reset();
        end else begin
            if (raise && m_inflight) begin
                m_inflight = 1'b0;
                free_edge  = edge_n + 1;
                exp_busy   = 1'b0;
            end
            if (!m_inflight && edge_n >= free_edge && rdy) begin
                locked = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
                if (m_holder >= 0) locked = lk[m_holder];
`endif
                elig = v;
                if (locked) elig = v & (NREQ'(1) << m_holder);
                if (elig != '0) begin
                    w          = pick(elig, m_last);
                    exp_start  = 1'b1;
                    exp_w      = w;
                    exp_ack    = NREQ'(1) << w;
                    exp_grant  = NREQ'(1) << w;
                    exp_data   = dat[w];
                    exp_busy   = 1'b1;
                    m_last     = w;
                    m_holder   = w;
                    m_inflight = 1'b1;
                end else if (!locked) begin
                    exp_grant = '0;
                    m_holder  = -1;
                end
            end
        end
        edge_n++;
    endtask

    task automatic apply_reset_async();
        #2 rst = 1'b1;
        #1;
        check_val("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check_val("rst_req_ack",  32'(bus.req_ack),  32'd0);
        check_val("rst_grant",    32'(bus.grant),    32'd0);
        check_val("rst_tx_data",  32'(bus.tx_data),  32'd0);
        check_val("rst_busy",     32'(bus.busy),     32'd0);
        model_reset();
        step(1'b1);
        step(1'b0);
    endtask

    task automatic drain(input int budget);
        int  n = 0;
        bit  active;
        active = 1'b1;
        while (active && n < budget) begin
            step(1'b0);
            n++;
            active = u_act || m_inflight || exp_start || (stall_left > 0);
            for (int i = 0; i < NREQ; i++) active = active || (srcq[i].size() > 0);
        end
        check_val("drain_timeout", 32'(n >= budget), 32'd0);
        repeat (2) step(1'b0);
    endtask

    task automatic wait_obs(input int count, input int budget);
        int n = 0;
        while (obs_q.size() < count && n < budget) begin
            step(1'b0);
            n++;
        end
        check_val("obs_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic check_order(input string tag, input logic [7:0] exp_seq [$]);
        check_val({tag, "_count"}, 32'(obs_q.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size(); i++) begin
            check_val(tag, 32'((i < obs_q.size()) ? obs_q[i] : 8'hxx), 32'(exp_seq[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_lock  = '0;
        bus.tx_ready  = 1'b1;
        v            = '0;
        lk           = '0;
        stall_left   = 0;
        u_act        = 1'b0;
        u_delay      = 0;
        u_low        = 0;
        force_long   = 1'b0;
        edge_n       = 0;
        for (int i = 0; i < NREQ; i++) begin
            hold[i] = 1'b0;
            pend[i] = 1'b0;
            cool[i] = 0;
            dat[i]  = 8'h00;
        end
        model_reset();
        repeat (3) step(1'b1);
        step(1'b0);

        // Single requester
        obs_q.delete();
        srcq[0].push_back(8'h41);
        drain(200);
        check_order("single", '{8'h41});

        // Contention from a fresh reset: 0 first, then alternate
        apply_reset_async();
        obs_q.delete();
        srcq[0].push_back(8'hA0); srcq[0].push_back(8'hA0);
        srcq[1].push_back(8'hB1); srcq[1].push_back(8'hB1);
        drain(400);
        check_order("contention", '{8'hA0, 8'hB1, 8'hA0, 8'hB1});

        // Wrap: after 3 is served, 0 beats 3
        obs_q.delete();
        srcq[3].push_back(8'h33);
        drain(200);
        srcq[3].push_back(8'h34);
        srcq[0].push_back(8'h30);
        drain(400);
        check_order("wrap", '{8'h33, 8'h30, 8'h34});

        // Packet lock
        obs_q.delete();
        lk[1] = 1'b1;
        srcq[1].push_back(8'hC1); srcq[1].push_back(8'hC2); srcq[1].push_back(8'hC3);
        wait_obs(1, 100);
        srcq[0].push_back(8'hD0);
        wait_obs(3, 400);
        repeat (20) step(1'b0);
        lk[1] = 1'b0;
        drain(400);
`ifdef UART_TX_ARB_LOCK_EN
        check_order("lock", '{8'hC1, 8'hC2, 8'hC3, 8'hD0});
`else
        check_order("lock", '{8'hC1, 8'hD0, 8'hC2, 8'hC3});
`endif

        // Reset in WAIT_BUSY, then a request held off by tx_ready low
        obs_q.delete();
        force_long = 1'b1;
        srcq[2].push_back(8'h52);
        wait_obs(1, 100);
        step(1'b0);
        check_val("busy_before_rst", 32'(bus.busy), 32'd1);
        srcq[3].push_back(8'h53);
        apply_reset_async();
        check_val("ready_low_after_rst", 32'(bus.tx_ready), 32'd0);
        drain(200);
        check_order("reset_mid", '{8'h52, 8'h53});

        // Ready stall
        obs_q.delete();
        stall_left = 50;
        srcq[0].push_back(8'h66);
        repeat (45) step(1'b0);
        check_val("stall_no_start", 32'(obs_q.size()), 32'd0);
        drain(200);
        check_order("stall", '{8'h66});

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (srcq[i].size() < 3 && $urandom_range(0, 7) == 0) srcq[i].push_back(8'($urandom));
                hold[i] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 39) == 0) lk[i] = ~lk[i];
            end
            if (!u_act && stall_left == 0 && $urandom_range(0, 49) == 0) stall_left = $urandom_range(1, 8);
            if (c == 1500) apply_reset_async();
            else step(1'b0);
        end
        for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
        lk = '0;
        drain(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` transmitter of the CSoC test controller between several byte sources: the command-parser echo/response path, the scan-out streamer and the CSoC UART bridge. Round-robin arbitration at byte granularity, with optional packet lock so multi-byte replies are not interleaved. Sits between the requesters and `uart_tx`, and sequences the `start`/`ready` handshake on their behalf.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..8.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input NREQ: requester i has a byte pending; must be held with data until `req_ack[i]`.
- `req_data` input 8*NREQ: byte of requester i at bits [8i+7:8i].
- `req_lock` input NREQ: requester i requests retention of the grant after its current byte.
- `req_ack` output NREQ: one-cycle pulse; byte of requester i accepted.
- `grant` output NREQ: one-hot owner of the transmitter; all zero when no owner.
- `tx_start` output 1: one-cycle start pulse to `uart_tx`.
- `tx_data` output 8: byte to `uart_tx`, registered, stable from `tx_start` until the next acceptance.
- `tx_ready` input 1: `uart_tx` idle flag; drops during transmission.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: when `tx_ready`=1 and at least one eligible `req_valid` is high, choose winner w and go to START. Eligible set: all requesters, except under lock (see Configuration).
- Round robin: pointer `last` holds index of the previous winner; search order is last+1, last+2, ..., wrapping modulo NREQ, with `last` itself checked last. Reset value of `last` = NREQ-1, so requester 0 wins first. `last` is updated to w on each acceptance.
- Entering START (registered): `tx_data`<=`req_data[w]`, `grant`<=one-hot(w), `req_ack[w]`=1 and `tx_start`=1 for exactly the START cycle.
- START -> WAIT_BUSY unconditionally.
- WAIT_BUSY -> WAIT_DONE when `tx_ready`=0.
- WAIT_DONE -> IDLE when `tx_ready`=1.
- `grant` is held through WAIT_DONE and IDLE until the next acceptance or until IDLE finds no eligible request. Without lock it then clears to 0.
- `req_valid` changes in IDLE with `tx_ready`=0 are ignored until `tx_ready`=1.
- Simultaneous requests: exactly one `req_ack` per accepted byte; no byte is accepted twice, because acceptance happens only from IDLE.
- Reset while active: all state returns immediately to IDLE and `tx_start` drops. A byte already handed to `uart_tx` completes on the line, and IDLE waits for `tx_ready`=1 before the next start.
- Reset values: `tx_start`=0, `tx_data`=8'h00, `req_ack`=0, `grant`=0, `busy`=0.

## Timing
- Latency from a valid request seen in IDLE (edge t) to `tx_start`/`req_ack` high: 1 cycle (cycle t+1).
- A requester may present its next byte from cycle t+2. That byte is accepted at the earliest 1 cycle after `tx_ready` returns high.
- Minimum spacing between two `tx_start` pulses: 4 cycles plus the `uart_tx` busy time.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `UART_TX_ARB_LOCK_EN` defined:
  - On return to IDLE, if the grant holder's `req_lock`=1, only the holder is eligible. The arbiter waits in IDLE with `grant` held, even if the holder's `req_valid`=0, until the holder sends again or drops `req_lock`.
  - Dropping `req_lock` takes effect at the next IDLE decision.
- Macro undefined: `req_lock` is ignored (port kept, unread), and every byte is arbitrated round robin.

## Test plan
- Single requester: NREQ=2, `req_valid`=2'b01, data 8'h41 -> one `tx_start` with `tx_data`=8'h41, `req_ack`=2'b01 one cycle later, `busy` high until `tx_ready` returns.
- Contention: both valid continuously, data 8'hA0/8'hB1 -> output order A0, B1, A0, B1; one ack per byte.
- Wrap: NREQ=4, requesters 3 and 0 valid after requester 3 was last served -> 0 wins, then 3.
- Lock (`UART_TX_ARB_LOCK_EN`): requester 1 sends 3 bytes with `req_lock`=1 while requester 0 is valid -> bytes of 1 are contiguous; requester 0 is served after `req_lock[1]` falls. With the macro undefined -> bytes interleave.
- Reset mid-byte: assert `rst` in WAIT_BUSY -> outputs return to reset values at once. A request after release with `tx_ready`=0 is held off until `tx_ready`=1, then `tx_start` follows 1 cycle later.
- Ready stall: `tx_ready`=0 for 50 cycles with a request pending -> no `tx_start` and no `req_ack` until `tx_ready`=1.
